// File: rtl/segment_transition_ctl.sv
// Segment swap-and-index controller: active segment, sample index, latched segment-change requests.
// Latency: requests and switches take effect one cycle after the strobe / qualifying TICK.
// Backpressure: none; a new request replaces any pending one, and invalid requests are dropped.
module segment_transition_ctl #(
   parameter int NUM_SEGMENT    = 2,
   parameter int SEG_W          = $clog2(NUM_SEGMENT),
   parameter int IDX_WIDTH      = 16,
   parameter int REP_WIDTH      = 16,
   parameter int SYS_TIME_WIDTH = 57,
   parameter int NUM_GPIO       = 4
) (
   input  logic                             CLK,
   input  logic                             RST,
   input  logic                             UPDATE_SETTINGS,
   input  logic [SEG_W-1:0]                 REQ_RD_SEGMENT,
   input  logic [REP_WIDTH-1:0]             REQ_REP,
   input  logic [7:0]                       TRANSITION_MODE,
   input  logic [63:0]                      TRANSITION_VALUE,
   input  logic [NUM_SEGMENT*IDX_WIDTH-1:0] CYCLE,
   input  logic                             TICK,
   input  logic [SYS_TIME_WIDTH-1:0]        SYS_TIME,
   input  logic [NUM_GPIO-1:0]              GPIO_IN,
   output logic [SEG_W-1:0]                 SEGMENT,
   output logic [IDX_WIDTH-1:0]             IDX,
   output logic                             STOP,
   output logic                             BUSY
);

   localparam int GPIO_SEL_W = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1;
   localparam logic [7:0] MODE_SYNC_IDX = 8'h00;
   localparam logic [7:0] MODE_SYS_TIME = 8'h01;
   localparam logic [7:0] MODE_GPIO     = 8'h02;
   localparam logic [7:0] MODE_EXT      = 8'hF0;
   localparam logic [SEG_W-1:0] LAST_SEG  = SEG_W'(NUM_SEGMENT - 1);
   localparam logic [SEG_W:0]   SEG_LIMIT = (SEG_W+1)'(NUM_SEGMENT);

   typedef enum logic [2:0] {ST_RUN, ST_PENDING, ST_FINITE, ST_STOPPED, ST_EXT_RUN} state_t;

   state_t                      state_q, state_d;
   logic [SEG_W-1:0]            seg_q, seg_d, req_seg_q, req_seg_d;
   logic [IDX_WIDTH-1:0]        idx_q, idx_d;
   logic                        stop_q, stop_d, busy_q, busy_d;
   logic [REP_WIDTH-1:0]        loop_q, loop_d, req_rep_q, req_rep_d;
   logic [7:0]                  req_mode_q, req_mode_d;
   logic [SYS_TIME_WIDTH-1:0]   req_val_q, req_val_d;

   logic [IDX_WIDTH-1:0]        cycle_cur;
   logic                        wrap, cond, req_ok, immediate;
   logic [GPIO_SEL_W-1:0]       gpio_sel;
   logic                        unused_val;

   // Only the system-time field of the argument is kept; GPIO select uses its low bits.
   assign unused_val = ^TRANSITION_VALUE[63:SYS_TIME_WIDTH];

   assign cycle_cur = CYCLE[int'(seg_q)*IDX_WIDTH +: IDX_WIDTH];
   assign wrap      = (idx_q == cycle_cur);
   assign gpio_sel  = req_val_q[GPIO_SEL_W-1:0];

   always_comb begin
      cond = wrap;
      case (req_mode_q)
         MODE_SYS_TIME: cond = (SYS_TIME >= req_val_q);
         MODE_GPIO:     cond = (int'(gpio_sel) < NUM_GPIO) && GPIO_IN[gpio_sel];
         default:       cond = wrap;
      endcase
   end

   assign req_ok = UPDATE_SETTINGS
                && ({1'b0, REQ_RD_SEGMENT} < SEG_LIMIT)
                && (TRANSITION_MODE == MODE_SYNC_IDX || TRANSITION_MODE == MODE_SYS_TIME ||
                    TRANSITION_MODE == MODE_GPIO     || TRANSITION_MODE == MODE_EXT);
   assign immediate = (&REQ_REP) && (TRANSITION_MODE != MODE_EXT);

   always_comb begin
      state_d    = state_q;
      seg_d      = seg_q;
      idx_d      = idx_q;
      stop_d     = stop_q;
      busy_d     = busy_q;
      loop_d     = loop_q;
      req_seg_d  = req_seg_q;
      req_rep_d  = req_rep_q;
      req_mode_d = req_mode_q;
      req_val_d  = req_val_q;

      // The TICK acts on the pre-update state; a same-cycle request is applied on top.
      if (TICK) begin
         case (state_q)
            ST_RUN: idx_d = wrap ? '0 : idx_q + 1'b1;
            ST_FINITE: begin
               if (!wrap) begin
                  idx_d = idx_q + 1'b1;
               end else if (loop_q == req_rep_q) begin
                  stop_d  = 1'b1;
                  state_d = ST_STOPPED;
               end else begin
                  loop_d = loop_q + 1'b1;
                  idx_d  = '0;
               end
            end
            ST_EXT_RUN: begin
               if (wrap) begin
                  idx_d = '0;
                  seg_d = (seg_q == LAST_SEG) ? '0 : seg_q + 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            ST_PENDING: begin
               if (cond) begin
                  seg_d   = req_seg_q;
                  idx_d   = '0;
                  busy_d  = 1'b0;
                  stop_d  = 1'b0;
                  loop_d  = '0;
                  state_d = (req_mode_q == MODE_EXT) ? ST_EXT_RUN : ST_FINITE;
               end else if (!stop_q) begin
                  // A request raised from STOPPED keeps the held index frozen.
                  idx_d = wrap ? '0 : idx_q + 1'b1;
               end
            end
            default: ;
         endcase
      end

      if (req_ok) begin
         if (immediate) begin
            seg_d   = REQ_RD_SEGMENT;
            idx_d   = '0;
            stop_d  = 1'b0;
            busy_d  = 1'b0;
            loop_d  = '0;
            state_d = ST_RUN;
         end else begin
            req_seg_d  = REQ_RD_SEGMENT;
            req_rep_d  = REQ_REP;
            req_mode_d = TRANSITION_MODE;
            req_val_d  = TRANSITION_VALUE[SYS_TIME_WIDTH-1:0];
            busy_d     = 1'b1;
            state_d    = ST_PENDING;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_RUN;
         seg_q      <= '0;
         idx_q      <= '0;
         stop_q     <= 1'b0;
         busy_q     <= 1'b0;
         loop_q     <= '0;
         req_seg_q  <= '0;
         req_rep_q  <= '0;
         req_mode_q <= '0;
         req_val_q  <= '0;
      end else begin
         state_q    <= state_d;
         seg_q      <= seg_d;
         idx_q      <= idx_d;
         stop_q     <= stop_d;
         busy_q     <= busy_d;
         loop_q     <= loop_d;
         req_seg_q  <= req_seg_d;
         req_rep_q  <= req_rep_d;
         req_mode_q <= req_mode_d;
         req_val_q  <= req_val_d;
      end
   end

   assign SEGMENT = seg_q;
   assign IDX     = idx_q;
   assign STOP    = stop_q;
   assign BUSY    = busy_q;

endmodule

// File: tb/tb_segment_transition_ctl.sv
// Directed bench for segment_transition_ctl: a 2-segment instance (with a wide select
// so out-of-range requests are expressible) and a 4-segment instance for EXT auto-hop.
module tb_segment_transition_ctl;

   logic        CLK = 1'b0;
   logic        RST, UPDATE_SETTINGS, TICK;
   logic [1:0]  REQ_RD_SEGMENT;
   logic [15:0] REQ_REP;
   logic [7:0]  TRANSITION_MODE;
   logic [63:0] TRANSITION_VALUE;
   logic [31:0] cycle_a;
   logic [63:0] cycle_b;
   logic [56:0] SYS_TIME;
   logic [3:0]  GPIO_IN;

   logic [1:0]  seg_a, seg_b;
   logic [15:0] idx_a, idx_b;
   logic        stop_a, stop_b, busy_a, busy_b;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   segment_transition_ctl #(.NUM_SEGMENT(2), .SEG_W(2)) dut_a (
      .CLK(CLK), .RST(RST), .UPDATE_SETTINGS(UPDATE_SETTINGS),
      .REQ_RD_SEGMENT(REQ_RD_SEGMENT), .REQ_REP(REQ_REP),
      .TRANSITION_MODE(TRANSITION_MODE), .TRANSITION_VALUE(TRANSITION_VALUE),
      .CYCLE(cycle_a), .TICK(TICK), .SYS_TIME(SYS_TIME), .GPIO_IN(GPIO_IN),
      .SEGMENT(seg_a), .IDX(idx_a), .STOP(stop_a), .BUSY(busy_a)
   );

   segment_transition_ctl #(.NUM_SEGMENT(4)) dut_b (
      .CLK(CLK), .RST(RST), .UPDATE_SETTINGS(UPDATE_SETTINGS),
      .REQ_RD_SEGMENT(REQ_RD_SEGMENT), .REQ_REP(REQ_REP),
      .TRANSITION_MODE(TRANSITION_MODE), .TRANSITION_VALUE(TRANSITION_VALUE),
      .CYCLE(cycle_b), .TICK(TICK), .SYS_TIME(SYS_TIME), .GPIO_IN(GPIO_IN),
      .SEGMENT(seg_b), .IDX(idx_b), .STOP(stop_b), .BUSY(busy_b)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock; outputs are read 1 time unit after the edge.
   task automatic step(input logic tk);
      TICK = tk;
      @(posedge CLK);
      #1;
      TICK = 1'b0;
      UPDATE_SETTINGS = 1'b0;
   endtask

   task automatic request(input logic [1:0] seg, input logic [15:0] rep,
                          input logic [7:0] mode, input logic [63:0] val);
      REQ_RD_SEGMENT   = seg;
      REQ_REP          = rep;
      TRANSITION_MODE  = mode;
      TRANSITION_VALUE = val;
      UPDATE_SETTINGS  = 1'b1;
      step(1'b0);
   endtask

   logic [15:0] seq1 [10] = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd2};
   logic [15:0] seq2 [5]  = '{16'd1, 16'd2, 16'd0, 16'd1, 16'd2};
   logic [1:0]  walk [4]  = '{2'd1, 2'd2, 2'd3, 2'd0};

   initial begin
      RST = 1'b1; UPDATE_SETTINGS = 1'b0; TICK = 1'b0;
      REQ_RD_SEGMENT = '0; REQ_REP = '0; TRANSITION_MODE = '0; TRANSITION_VALUE = '0;
      cycle_a = {16'd2, 16'd3};
      cycle_b = {4{16'd1}};
      SYS_TIME = '0; GPIO_IN = '0;
      step(1'b0);
      step(1'b0);
      check("rst_seg",  seg_a,  0);
      check("rst_idx",  idx_a,  0);
      check("rst_stop", stop_a, 0);
      check("rst_busy", busy_a, 0);
      RST = 1'b0;

      // Free run on segment 0, CYCLE0=3
      for (int i = 0; i < 10; i++) begin
         step(1'b1);
         check("run_idx", idx_a, seq1[i]);
      end
      check("run_seg",  seg_a,  0);
      check("run_stop", stop_a, 0);
      check("run_busy", busy_a, 0);

      // SYNC_IDX to segment 1, REP=1, issued at IDX=1
      for (int i = 0; i < 3; i++) step(1'b1);
      check("sync_pre_idx", idx_a, 1);
      request(2'd1, 16'd1, 8'h00, 64'd0);
      check("sync_busy", busy_a, 1);
      check("sync_hold_seg", seg_a, 0);
      step(1'b1);
      step(1'b1);
      check("sync_old_idx", idx_a, 3);
      check("sync_old_seg", seg_a, 0);
      step(1'b1);
      check("sync_sw_seg",  seg_a,  1);
      check("sync_sw_idx",  idx_a,  0);
      check("sync_sw_busy", busy_a, 0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1);
         check("fin_idx", idx_a, seq2[i]);
         check("fin_stop", stop_a, 0);
      end
      step(1'b1);
      check("fin_stop_set", stop_a, 1);
      check("fin_stop_idx", idx_a, 2);
      step(1'b1);
      step(1'b1);
      check("stopped_idx",  idx_a,  2);
      check("stopped_seg",  seg_a,  1);
      check("stopped_stop", stop_a, 1);

      // SYS_TIME to segment 0, REP=0, value 1000, raised from STOPPED
      request(2'd0, 16'd0, 8'h01, 64'd1000);
      check("st_busy", busy_a, 1);
      check("st_stop_kept", stop_a, 1);
      SYS_TIME = 57'd998;
      step(1'b1);
      check("st_998_seg", seg_a, 1);
      check("st_998_idx", idx_a, 2);
      SYS_TIME = 57'd999;
      step(1'b1);
      check("st_999_seg", seg_a, 1);
      check("st_999_busy", busy_a, 1);
      SYS_TIME = 57'd1000;
      step(1'b1);
      check("st_sw_seg",  seg_a,  0);
      check("st_sw_busy", busy_a, 0);
      check("st_sw_stop", stop_a, 0);
      check("st_sw_idx",  idx_a,  0);
      for (int i = 0; i < 3; i++) step(1'b1);
      check("rep0_last_idx", idx_a, 3);
      check("rep0_not_stop", stop_a, 0);
      step(1'b1);
      check("rep0_stop", stop_a, 1);
      check("rep0_idx",  idx_a,  3);

      // GPIO to segment 1 on pin 2
      request(2'd1, 16'd0, 8'h02, 64'd2);
      GPIO_IN = 4'b1011;
      step(1'b1);
      check("gpio_off_seg",  seg_a,  0);
      check("gpio_off_busy", busy_a, 1);
      GPIO_IN = 4'b0100;
      step(1'b1);
      check("gpio_sw_seg",  seg_a,  1);
      check("gpio_sw_busy", busy_a, 0);
      check("gpio_sw_idx",  idx_a,  0);
      GPIO_IN = 4'b0000;

      // Invalid requests are dropped
      request(2'd3, 16'd5, 8'h00, 64'd0);
      check("bad_seg_busy", busy_a, 0);
      check("bad_seg_seg",  seg_a,  1);
      request(2'd0, 16'd5, 8'h05, 64'd0);
      check("bad_mode_busy", busy_a, 0);
      check("bad_mode_seg",  seg_a,  1);

      // Immediate request, then reset while pending
      request(2'd0, 16'hFFFF, 8'h00, 64'd0);
      check("imm_seg",  seg_a,  0);
      check("imm_idx",  idx_a,  0);
      check("imm_busy", busy_a, 0);
      step(1'b1);
      check("imm_run_idx", idx_a, 1);
      request(2'd1, 16'd0, 8'h00, 64'd0);
      check("pend_busy", busy_a, 1);
      RST = 1'b1;
      step(1'b0);
      RST = 1'b0;
      check("rst_pend_seg",  seg_a,  0);
      check("rst_pend_busy", busy_a, 0);
      check("rst_pend_idx",  idx_a,  0);

      // EXT auto-hop on the 4-segment instance, all CYCLE=1
      request(2'd0, 16'd3, 8'hF0, 64'd0);
      check("ext_busy", busy_b, 1);
      step(1'b1);
      check("ext_pre_idx", idx_b, 1);
      step(1'b1);
      check("ext_sw_seg",  seg_b,  0);
      check("ext_sw_idx",  idx_b,  0);
      check("ext_sw_busy", busy_b, 0);
      for (int k = 0; k < 4; k++) begin
         step(1'b1);
         step(1'b1);
         check("ext_walk_seg", seg_b, walk[k]);
         check("ext_walk_idx", idx_b, 0);
      end
      step(1'b1);
      step(1'b1);
      step(1'b1);
      check("ext_mid_seg", seg_b, 1);
      check("ext_mid_idx", idx_b, 1);
      request(2'd2, 16'hFFFF, 8'h00, 64'd0);
      check("ext_imm_seg",  seg_b,  2);
      check("ext_imm_idx",  idx_b,  0);
      check("ext_imm_busy", busy_b, 0);
      step(1'b1);
      step(1'b1);
      check("ext_run_nohop_seg", seg_b, 2);
      check("ext_run_nohop_idx", idx_b, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
